// File: rtl/clb_cfg_pkg.sv
// clb_cfg_pkg: definitions shared by the CLB configuration transmitter and
// the CLB that consumes its bitstream.
//   - field widths of the per-input type/index records
//   - t_input_type: encoding of a LUT input source
//   - t_tx_state:   transmitter frame states
//   - frame_len():  number of cycles cfg stays high for one frame
// Optional build macro: CLB_CFG_TX_PARITY_EN (adds one even-parity bit per frame).
package clb_cfg_pkg;

  localparam int BIT_STREAM_SIGNAL_TYPE_W     = 2;
  localparam int BIT_STREAM_SIGNAL_IDX_LENGTH = 8;

  typedef enum logic [1:0] {
    IT_NEIGHBOUR = 2'd0,
    IT_IO        = 2'd1,
    IT_FEEDBACK  = 2'd2
  } t_input_type;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_TYPE,
    ST_INDEX,
    ST_PAD,
    ST_TT,
    ST_PARITY,
    ST_DONE
  } t_tx_state;

  // Lead bit + (type + index + pad) per input + truth table [+ parity].
  function automatic int frame_len(input int lut_width);
    int f;
    f = 1 + (BIT_STREAM_SIGNAL_TYPE_W + BIT_STREAM_SIGNAL_IDX_LENGTH + 1) * lut_width
          + (1 << lut_width);
`ifdef CLB_CFG_TX_PARITY_EN
    f = f + 1;
`endif
    return f;
  endfunction

endpackage

// File: rtl/clb_cfg_tx.sv
// clb_cfg_tx: serial configuration transmitter for one CLB.
// Accepts a complete CLB configuration in parallel (valid/ready), then emits it
// one bit per cycle: LEAD zero, per input {type MSB-first, index LSB-first, pad
// zero}, truth table bit 0 first, optional parity, then a DONE cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_valid/ready    parallel load handshake (ready only in IDLE)
//   load_types          2 bits per LUT input, input i at [2i+1:2i]
//   load_indices        8 bits per LUT input, input i at [8i+7:8i]
//   load_truth_table    LUT_DEPTH bits, bit k = output for input vector k
//   cfg, cfg_clb_data   frame strobe and serial data to the CLB
//   busy, done, err     frame active, end-of-frame pulse, rejected-load pulse
// Optional build macro: CLB_CFG_TX_PARITY_EN (PARITY state after TT).
module clb_cfg_tx #(
  parameter  int LUT_WIDTH = 4,
  localparam int LUT_DEPTH = 1 << LUT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [2*LUT_WIDTH-1:0] load_types,
  input  logic [8*LUT_WIDTH-1:0] load_indices,
  input  logic [LUT_DEPTH-1:0]   load_truth_table,
  output logic                   cfg,
  output logic                   cfg_clb_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  import clb_cfg_pkg::*;

  localparam int TW    = BIT_STREAM_SIGNAL_TYPE_W;
  localparam int IW    = BIT_STREAM_SIGNAL_IDX_LENGTH;
  localparam int BIT_W = $clog2((LUT_DEPTH > IW) ? LUT_DEPTH : IW);
  localparam int IN_W  = (LUT_WIDTH > 1) ? $clog2(LUT_WIDTH) : 1;

  localparam logic [BIT_W-1:0] TYPE_LAST  = BIT_W'(TW - 1);
  localparam logic [BIT_W-1:0] INDEX_LAST = BIT_W'(IW - 1);
  localparam logic [BIT_W-1:0] TT_LAST    = BIT_W'(LUT_DEPTH - 1);
  localparam logic [IN_W-1:0]  IN_LAST    = IN_W'(LUT_WIDTH - 1);

  t_tx_state                state_q, state_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [IN_W-1:0]          in_q, in_d;
  logic [TW*LUT_WIDTH-1:0]  types_q, types_d;
  logic [IW*LUT_WIDTH-1:0]  idx_q, idx_d;
  logic [LUT_DEPTH-1:0]     tt_q, tt_d;
  logic                     cfg_q, cfg_d;
  logic                     data_q, data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
`ifdef CLB_CFG_TX_PARITY_EN
  logic                     parity_q, parity_d;
`endif

  logic [LUT_WIDTH-1:0]     type_bad;
  logic [TW-1:0]            cur_type;
  logic [IW-1:0]            cur_idx;

  // Type code 2'b11 is unassigned; a load containing it is rejected whole.
  genvar gi;
  generate
    for (gi = 0; gi < LUT_WIDTH; gi++) begin : g_type_chk
      assign type_bad[gi] = (load_types[TW*gi +: TW] == {TW{1'b1}});
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    in_d    = in_q;
    types_d = types_q;
    idx_d   = idx_q;
    tt_d    = tt_q;
    err_d   = 1'b0;
`ifdef CLB_CFG_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          if (|type_bad) begin
            err_d = 1'b1;
          end else begin
            types_d = load_types;
            idx_d   = load_indices;
            tt_d    = load_truth_table;
            bit_d   = '0;
            in_d    = '0;
            state_d = ST_LEAD;
`ifdef CLB_CFG_TX_PARITY_EN
            parity_d = 1'b0;
`endif
          end
        end
      end
      ST_LEAD: begin
        bit_d   = '0;
        in_d    = '0;
        state_d = ST_TYPE;
      end
      ST_TYPE: begin
        if (bit_q == TYPE_LAST) begin
          bit_d   = '0;
          state_d = ST_INDEX;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      ST_INDEX: begin
        if (bit_q == INDEX_LAST) begin
          bit_d   = '0;
          state_d = ST_PAD;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      ST_PAD: begin
        bit_d = '0;
        if (in_q == IN_LAST) begin
          in_d    = '0;
          state_d = ST_TT;
        end else begin
          in_d    = in_q + IN_W'(1);
          state_d = ST_TYPE;
        end
      end
      ST_TT: begin
        if (bit_q == TT_LAST) begin
          bit_d = '0;
`ifdef CLB_CFG_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_DONE;
`endif
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
`ifdef CLB_CFG_TX_PARITY_EN
      ST_PARITY: begin
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        bit_d   = '0;
        in_d    = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so the bit for the state being entered is
    // computed here; captured fields are already in place by the first TYPE.
    cur_type = types_q[TW*int'(in_d) +: TW];
    cur_idx  = idx_q[IW*int'(in_d) +: IW];
    data_d   = 1'b0;
    case (state_d)
      ST_TYPE:  data_d = cur_type[~bit_d[0]];
      ST_INDEX: data_d = (cur_type == IT_FEEDBACK) ? 1'b0 : cur_idx[bit_d[$clog2(IW)-1:0]];
      ST_TT:    data_d = tt_q[bit_d];
`ifdef CLB_CFG_TX_PARITY_EN
      ST_PARITY: data_d = parity_q;
`endif
      default:  data_d = 1'b0;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    cfg_d  = busy_d;
    done_d = (state_d == ST_DONE);
`ifdef CLB_CFG_TX_PARITY_EN
    // LEAD/PAD contribute zeros, so folding every emitted bit is harmless.
    parity_d = parity_d ^ data_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      in_q    <= '0;
      types_q <= '0;
      idx_q   <= '0;
      tt_q    <= '0;
      cfg_q   <= 1'b0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CLB_CFG_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      in_q    <= in_d;
      types_q <= types_d;
      idx_q   <= idx_d;
      tt_q    <= tt_d;
      cfg_q   <= cfg_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CLB_CFG_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign load_ready   = (state_q == ST_IDLE);
  assign cfg          = cfg_q;
  assign cfg_clb_data = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_clb_cfg_tx.sv
// Scoreboard bench for clb_cfg_tx (LUT_WIDTH = 4): each accepted load pushes
// its expected serial bits; the monitor pops one bit per frame cycle.
module tb_clb_cfg_tx;
  import clb_cfg_pkg::*;

  localparam int LW = 4;
  localparam int LD = 1 << LW;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_valid;
  logic            load_ready;
  logic [2*LW-1:0] load_types;
  logic [8*LW-1:0] load_indices;
  logic [LD-1:0]   load_truth_table;
  logic            cfg, cfg_clb_data, busy, done, err;

  always #5 clk = ~clk;

  clb_cfg_tx #(.LUT_WIDTH(LW)) dut (
    .clk              (clk),
    .rst              (rst),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_types       (load_types),
    .load_indices     (load_indices),
    .load_truth_table (load_truth_table),
    .cfg              (cfg),
    .cfg_clb_data     (cfg_clb_data),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and monitor state
  bit  exp_bits[$];
  int  accept_cnt  = 0;
  int  frames_end  = 0;
  int  run_len     = 0;
  int  low_run     = 0;
  int  rst_pulses  = 0;
  int  seen_pulses = 0;
  bit  in_reset    = 0;
  bit  err_exp     = 0;
  bit  model_prev_act = 0;
  bit  prev_cfg    = 0;
  bit  hold_ok     = 0;
  bit  exp_act, exp_done, exp_bit, bad;

  task automatic push_frame(input logic [2*LW-1:0] ty, input logic [8*LW-1:0] ix,
                            input logic [LD-1:0] tt);
    logic [1:0] t;
    logic [7:0] v;
    bit p;
    p = 1'b0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < LW; i++) begin
      t = ty[2*i +: 2];
      exp_bits.push_back(t[1]);
      exp_bits.push_back(t[0]);
      p = p ^ t[1] ^ t[0];
      v = (t == 2'd2) ? 8'h00 : ix[8*i +: 8];
      for (int b = 0; b < 8; b++) begin
        exp_bits.push_back(v[b]);
        p = p ^ v[b];
      end
      exp_bits.push_back(1'b0);
    end
    for (int k = 0; k < LD; k++) begin
      exp_bits.push_back(tt[k]);
      p = p ^ tt[k];
    end
`ifdef CLB_CFG_TX_PARITY_EN
    exp_bits.push_back(p);
`endif
    $display("txn %0t accept types=%h idx=%h tt=%h parity=%0d", $time, ty, ix, tt, p);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      in_reset = 1'b1;
    end else if (in_reset || (rst_pulses != seen_pulses)) begin
      check_eq("rst_cfg",   cfg, 1'b0);
      check_eq("rst_data",  cfg_clb_data, 1'b0);
      check_eq("rst_busy",  busy, 1'b0);
      check_eq("rst_done",  done, 1'b0);
      check_eq("rst_err",   err, 1'b0);
      check_eq("rst_ready", load_ready, 1'b1);
      exp_bits.delete();
      in_reset       = 1'b0;
      seen_pulses    = rst_pulses;
      model_prev_act = 1'b0;
      prev_cfg       = 1'b0;
      hold_ok        = 1'b0;
      run_len        = 0;
      low_run        = 0;
      err_exp        = 1'b0;
    end else begin
      exp_act  = (exp_bits.size() != 0);
      exp_done = model_prev_act && !exp_act;
      check_eq("cfg",   cfg, exp_act);
      check_eq("busy",  busy, exp_act);
      check_eq("ready", load_ready, !exp_act && !exp_done);
      check_eq("done",  done, exp_done);
      check_eq("err",   err, err_exp);
      if (exp_act) begin
        exp_bit = exp_bits.pop_front();
        check_eq("data", cfg_clb_data, exp_bit);
      end else begin
        check_eq("idle_data", cfg_clb_data, 1'b0);
      end
      model_prev_act = exp_act;

      if (!cfg) begin
        if (prev_cfg) begin
          frames_end++;
          check_eq("frame_len", run_len, frame_len(LW));
          $display("txn %0t frame_end len=%0d", $time, run_len);
          hold_ok = load_valid;
          low_run = 0;
          run_len = 0;
        end else begin
          hold_ok = hold_ok && load_valid;
        end
        low_run++;
      end else begin
        if (!prev_cfg) begin
          if (hold_ok) check_eq("b2b_gap", low_run, 2);
          hold_ok = 1'b0;
        end
        run_len++;
      end
      prev_cfg = cfg;
    end

    // Predict the handshake at the coming edge.
    err_exp = 1'b0;
    if (!rst && load_valid && load_ready) begin
      accept_cnt++;
      bad = 1'b0;
      for (int i = 0; i < LW; i++)
        if (load_types[2*i +: 2] == 2'b11) bad = 1'b1;
      if (bad) begin
        err_exp = 1'b1;
        $display("txn %0t reject types=%h", $time, load_types);
      end else begin
        push_frame(load_types, load_indices, load_truth_table);
      end
    end
  end

  task automatic scramble();
    load_types       = 8'($urandom);
    load_indices     = $urandom;
    load_truth_table = 16'($urandom);
  endtask

  task automatic wait_frame_end(input int start);
    for (int c = 0; c < 200 && frames_end == start; c++) begin
      @(posedge clk); #1;
    end
    if (frames_end == start) check_eq("frame_timeout", frames_end, start + 1);
  endtask

  task automatic send(input logic [2*LW-1:0] ty, input logic [8*LW-1:0] ix,
                      input logic [LD-1:0] tt, input bit wait_end);
    int a0, f0;
    a0 = accept_cnt;
    f0 = frames_end;
    load_types       = ty;
    load_indices     = ix;
    load_truth_table = tt;
    load_valid       = 1'b1;
    for (int c = 0; c < 20 && accept_cnt == a0; c++) begin
      @(posedge clk); #1;
    end
    if (accept_cnt == a0) check_eq("accept_timeout", accept_cnt, a0 + 1);
    load_valid = 1'b0;
    scramble();   // must not leak into the running frame
    if (wait_end) wait_frame_end(f0);
  endtask

  task automatic pulse_rst();
    @(negedge clk); #1;
    rst = 1'b1;
    rst_pulses++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int f0;
    rst = 1'b1;
    load_valid = 1'b0;
    load_types = '0;
    load_indices = '0;
    load_truth_table = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Mixed types: input1 FEEDBACK so its index must go out as zeros.
    send(8'b00_01_10_00, 32'h81A73C05, 16'h6996, 1'b1);
    repeat (2) @(posedge clk); #1;
    // All IO, index 0xFF everywhere.
    send(8'b01_01_01_01, 32'hFFFFFFFF, 16'hA5C3, 1'b1);
    repeat (2) @(posedge clk); #1;
    // Input 1 type 2'b11: rejected with an err pulse, no frame.
    send(8'b00_00_11_00, 32'h11223344, 16'hFFFF, 1'b0);
    repeat (4) @(posedge clk); #1;
    // Next valid load accepted normally; single truth-table bit set.
    send(8'b00_00_00_00, 32'h00000000, 16'h0001, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Abort mid-frame at frame cycle 20, then a fresh complete frame.
    send(8'b00_01_00_01, 32'hDEADBEEF, 16'hFFFF, 1'b0);
    for (int c = 0; c < 100 && run_len < 20; c++) @(negedge clk);
    if (run_len < 20) check_eq("rst_wait_timeout", run_len, 20);
    pulse_rst();
    repeat (3) @(posedge clk); #1;
    send(8'b00_01_00_01, 32'hDEADBEEF, 16'h8001, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Back-to-back with load_valid held and load_* changing every cycle.
    f0 = frames_end;
    load_valid = 1'b1;
    for (int c = 0; c < 400 && (frames_end - f0) < 3; c++) begin
      for (int i = 0; i < LW; i++) load_types[2*i +: 2] = 2'($urandom_range(0, 2));
      load_indices     = $urandom;
      load_truth_table = 16'($urandom);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    if ((frames_end - f0) < 3) check_eq("b2b_timeout", frames_end - f0, 3);

    repeat (5) @(posedge clk); #1;
    check_eq("leftover_bits", exp_bits.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clb_cfg_tx.md
Name: clb_cfg_tx

Overview:
Serial configuration transmitter that drives the cfg / cfg_clb_data bitstream consumed by a CLB. It accepts one complete CLB configuration as parallel fields through a valid/ready handshake, then serializes it, one bit per cycle, in the CLB bitstream order. It sits between the top-level configuration controller and each CLB's cfg inputs.

Parameters:
LUT_WIDTH, 4, number of LUT inputs in the target CLB.
LUT_DEPTH, 1 << LUT_WIDTH, truth-table bit count. Derived; not overridden.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
load_valid  in  1  parallel config available
load_ready  out  1  high when IDLE; a transfer happens when load_valid && load_ready
load_types  in  2*LUT_WIDTH  input type per LUT input; input i occupies [2i+1:2i]
load_indices  in  8*LUT_WIDTH  signal index per LUT input; input i occupies [8i+7:8i]
load_truth_table  in  LUT_DEPTH  truth table; bit k = LUT output for input vector k
cfg  out  1  frame-active strobe to the CLB
cfg_clb_data  out  1  serial config bit
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last frame bit
err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset values: cfg=0, cfg_clb_data=0, busy=0, done=0, err=0, load_ready=1, FSM=IDLE, all counters 0.
- States: IDLE, LEAD, TYPE, INDEX, PAD, TT, (PARITY), DONE.
- IDLE: load_ready=1. On a handshake, validate every 2-bit type field.
  - Any field == 2'b11: do not capture, pulse err the next cycle, stay in IDLE.
  - Otherwise: capture all fields into internal registers and go to LEAD.
  - Later changes on the load_* ports do not affect a running frame.
- LEAD: 1 cycle, cfg=1, data=0. This lets the CLB leave INIT.
- Per LUT input i, for i = 0..LUT_WIDTH-1:
  - TYPE: 2 cycles, type bits MSB first.
  - INDEX: 8 cycles, index bits LSB first.
  - PAD: 1 cycle, data=0. This fills the CLB's per-input END cycle.
- TT: LUT_DEPTH cycles, truth table bit 0 first.
- DONE: 1 cycle, cfg=0, data=0, done=1, then IDLE.
- cfg=1 and busy=1 in every state from LEAD through the last TT (or PARITY) cycle; otherwise 0.
- Frame length with cfg high is F = 1 + 11*LUT_WIDTH + LUT_DEPTH (61 at the default).
- The first frame bit appears the cycle after the accepting handshake. Back-to-back loads: the earliest next accept is in the IDLE cycle following DONE.
- Counters:
  - bit counter width: $clog2(max(8, LUT_DEPTH)).
  - input counter width: $clog2(LUT_WIDTH), minimum 1.
  - Counters reset to 0 on each state entry. No wrap-around is ever observed on a valid frame.
- Input type encoding: 0 NEIGHBOUR, 1 IO, 2 FEEDBACK. For FEEDBACK the 8 index bits are still sent, as all zeros, regardless of load_indices.
- rst mid-frame: on the next edge all outputs return to reset values and the frame is abandoned. No done pulse. A partial frame is not resumed.
- load_valid asserted while busy: ignored, because load_ready=0.

Optional Feature:
CLB_CFG_TX_PARITY_EN
- Defined: a PARITY state (1 cycle, cfg=1) follows TT and sends even parity, i.e. the XOR of all data bits from the first TYPE bit through the last TT bit. The LEAD and PAD zeros do not change the result. F increases by 1.
- Undefined: no PARITY state; TT goes directly to DONE.

Decomposition:
- Package clb_cfg_pkg holds:
  - BIT_STREAM_SIGNAL_TYPE_W = 2
  - BIT_STREAM_SIGNAL_IDX_LENGTH = 8
  - t_input_type enum, shared with the CLB
  - frame-length function f(LUT_WIDTH)
- Optional sub-module clb_cfg_tx_shreg: a loadable parallel-in/serial-out shift register with selectable LSB/MSB-first direction.
  - One instance for the current type/index field.
  - One instance for the truth table.

Test Plan:
- LUT_WIDTH=2; types {FEEDBACK, NEIGHBOUR}, indices {0x00, 0x05}, truth table 4'b0110 -> cfg high exactly 27 cycles. Serial stream: 0, 00, 10100000, 0, 10, 00000000, 0, 0110. done pulses 1 cycle after cfg falls.
- Default LUT_WIDTH=4, all-IO types, index 0xFF -> cfg high 61 cycles. Index bits all 1. busy=1 throughout. load_ready=0 throughout.
- Load with input 1 type = 2'b11 -> err pulses once, cfg stays 0, next valid load is accepted normally.
- rst asserted at frame cycle 20 -> next cycle: cfg=0, busy=0, load_ready=1, no done. A fresh load produces a full correct frame.
- load_valid held high continuously -> frames separated by exactly the DONE + IDLE cycles. load_* changes mid-frame do not appear in the stream.
- With CLB_CFG_TX_PARITY_EN, truth table 4'b0001, all other bits 0 -> frame 62 cycles, final bit 1. Connected to a CLB instance, the CLB reaches IDLE with the programmed truth table.
